// File: rtl/prio_grant_decoder.sv
// Registered priority-code decoder: accepts a 2-bit priority code per handshake,
// expands it to a one-hot grant, holds it for HOLD_CYCLES cycles, then pulses done.
module prio_grant_decoder #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [2:0] grant,
    output logic       grant_valid,
    output logic       done,
    output logic [7:0] grant_count
);

    // Zero behaves as one; anything beyond the 8-bit counter range is clamped.
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : ((HOLD_CYCLES > 255) ? 255 : HOLD_CYCLES);
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_EFF - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t     state_reg;
    logic [7:0] hold_cnt_reg;
    logic [2:0] onehot;
    logic       accept;

    // Bit gi of the grant corresponds to code value gi+1 (c=01, b=10, a=11).
    for (genvar gi = 0; gi < 3; gi++) begin : g_decode
        assign onehot[gi] = (code_in == 2'(gi + 1));
    end

    assign accept = code_valid && code_ready && (onehot != 3'b000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= 8'd0;
            code_ready   <= 1'b0;
            grant        <= 3'b000;
            grant_valid  <= 1'b0;
            done         <= 1'b0;
            grant_count  <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    code_ready <= 1'b1;
                    done       <= 1'b0;
                    if (accept) begin
                        state_reg    <= HOLD;
                        hold_cnt_reg <= HOLD_LOAD;
                        code_ready   <= 1'b0;
                        grant        <= onehot;
                        grant_valid  <= 1'b1;
                        done         <= (HOLD_LOAD == 8'd0);
                        if (grant_count != 8'd255) begin
                            grant_count <= grant_count + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == 8'd0) begin
                        state_reg   <= IDLE;
                        code_ready  <= 1'b1;
                        grant       <= 3'b000;
                        grant_valid <= 1'b0;
                        done        <= 1'b0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 8'd1;
                        done         <= (hold_cnt_reg == 8'd1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prio_grant_decoder.sv
// Bench for prio_grant_decoder: directed vector table (HOLD_CYCLES=4), then random
// and saturation runs checked against a cycle-count reference model for HOLD 4, 1 and 0.
module tb_prio_grant_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] code_in;
    logic       code_valid;

    logic [2:0]       rdy;
    logic [2:0][2:0]  gnt;
    logic [2:0]       gv;
    logic [2:0]       dn;
    logic [2:0][7:0]  cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prio_grant_decoder #(.HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(rdy[0]), .grant(gnt[0]), .grant_valid(gv[0]), .done(dn[0]),
        .grant_count(cnt[0])
    );
    prio_grant_decoder #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(rdy[1]), .grant(gnt[1]), .grant_valid(gv[1]), .done(dn[1]),
        .grant_count(cnt[1])
    );
    prio_grant_decoder #(.HOLD_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .code_ready(rdy[2]), .grant(gnt[2]), .grant_valid(gv[2]), .done(dn[2]),
        .grant_count(cnt[2])
    );

    // Reference model: remaining hold cycles, latched grant, saturating count.
    int         m_hold [2] = '{4, 1};
    int         m_rem  [2] = '{0, 0};
    int         m_cnt  [2] = '{0, 0};
    logic [2:0] m_grant[2] = '{3'b000, 3'b000};
    logic       m_ready[2] = '{1'b0, 1'b0};

    task automatic mstep(input int m, input logic r, input logic v, input logic [1:0] c);
        if (r) begin
            m_rem[m] = 0; m_cnt[m] = 0; m_grant[m] = 3'b000; m_ready[m] = 1'b0;
        end else if (m_rem[m] > 0) begin
            m_rem[m] = m_rem[m] - 1;
            if (m_rem[m] == 0) begin
                m_grant[m] = 3'b000;
                m_ready[m] = 1'b1;
            end
        end else if (m_ready[m] && v && c != 2'b00) begin
            m_grant[m] = 3'b100 >> (3 - c);
            m_rem[m]   = m_hold[m];
            m_cnt[m]   = (m_cnt[m] < 255) ? m_cnt[m] + 1 : 255;
            m_ready[m] = 1'b0;
        end else begin
            m_ready[m] = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] c);
        int m;
        rst = r; code_valid = v; code_in = c;
        @(posedge clk);
        mstep(0, r, v, c);
        mstep(1, r, v, c);
        #1;
        for (int d = 0; d < 3; d++) begin
            m = (d == 0) ? 0 : 1;
            chk($sformatf("model_ready[%0d]", d), 32'(rdy[d]), 32'(m_ready[m]));
            chk($sformatf("model_grant[%0d]", d), 32'(gnt[d]), 32'(m_grant[m]));
            chk($sformatf("model_gvalid[%0d]", d), 32'(gv[d]), 32'(m_rem[m] > 0));
            chk($sformatf("model_done[%0d]", d), 32'(dn[d]), 32'(m_rem[m] == 1));
            chk($sformatf("model_count[%0d]", d), 32'(cnt[d]), 32'(m_cnt[m]));
        end
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] c;
        logic       rdy;
        logic [2:0] g;
        logic       d;
        int         cnt;
    } vec_t;

    vec_t vec[26];

    initial begin
        int accepted;
        logic was_ready;
        logic [1:0] cc;

        vec[0]  = '{1, 1, 3, 0, 3'b000, 0, 0};  // reset beats valid
        vec[1]  = '{1, 0, 0, 0, 3'b000, 0, 0};
        vec[2]  = '{0, 1, 3, 1, 3'b000, 0, 0};  // ready rises, nothing accepted yet
        vec[3]  = '{0, 1, 3, 0, 3'b100, 0, 1};
        vec[4]  = '{0, 1, 2, 0, 3'b100, 0, 1};
        vec[5]  = '{0, 0, 0, 0, 3'b100, 0, 1};
        vec[6]  = '{0, 1, 1, 0, 3'b100, 1, 1};
        vec[7]  = '{0, 0, 0, 1, 3'b000, 0, 1};
        vec[8]  = '{0, 1, 2, 0, 3'b010, 0, 2};
        vec[9]  = '{0, 1, 1, 0, 3'b010, 0, 2};
        vec[10] = '{0, 1, 1, 0, 3'b010, 0, 2};
        vec[11] = '{0, 1, 1, 0, 3'b010, 1, 2};
        vec[12] = '{0, 1, 1, 1, 3'b000, 0, 2};
        vec[13] = '{0, 1, 1, 0, 3'b001, 0, 3};
        vec[14] = '{0, 0, 0, 0, 3'b001, 0, 3};
        vec[15] = '{0, 0, 0, 0, 3'b001, 0, 3};
        vec[16] = '{0, 0, 0, 0, 3'b001, 1, 3};
        vec[17] = '{0, 1, 0, 1, 3'b000, 0, 3};
        vec[18] = '{0, 1, 0, 1, 3'b000, 0, 3};
        vec[19] = '{0, 1, 0, 1, 3'b000, 0, 3};
        vec[20] = '{0, 1, 0, 1, 3'b000, 0, 3};
        vec[21] = '{0, 1, 3, 0, 3'b100, 0, 4};
        vec[22] = '{0, 0, 0, 0, 3'b100, 0, 4};
        vec[23] = '{1, 1, 2, 0, 3'b000, 0, 0};  // reset on 2nd hold cycle
        vec[24] = '{0, 1, 2, 1, 3'b000, 0, 0};
        vec[25] = '{0, 1, 2, 0, 3'b010, 0, 1};

        for (int i = 0; i < 26; i++) begin
            step(vec[i].r, vec[i].v, vec[i].c);
            chk($sformatf("vec%0d_ready", i), 32'(rdy[0]), 32'(vec[i].rdy));
            chk($sformatf("vec%0d_grant", i), 32'(gnt[0]), 32'(vec[i].g));
            chk($sformatf("vec%0d_gvalid", i), 32'(gv[0]), 32'(vec[i].g != 3'b000));
            chk($sformatf("vec%0d_done", i), 32'(dn[0]), 32'(vec[i].d));
            chk($sformatf("vec%0d_count", i), 32'(cnt[0]), 32'(vec[i].cnt));
            $display("vec %0d: rst=%0d valid=%0d code=%0d -> ready=%0d grant=%03b done=%0d count=%0d",
                     i, vec[i].r, vec[i].v, vec[i].c, rdy[0], gnt[0], dn[0], cnt[0]);
        end

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
            $display("rnd %0d: ready=%0d/%0d/%0d grant=%03b/%03b/%03b count=%0d/%0d/%0d",
                     i, rdy[0], rdy[1], rdy[2], gnt[0], gnt[1], gnt[2], cnt[0], cnt[1], cnt[2]);
        end

        step(1'b1, 1'b0, 2'b00);
        accepted = 0;
        for (int i = 0; i < 1000 && accepted < 300; i++) begin
            was_ready = m_ready[1];
            cc = 2'($urandom_range(1, 3));
            step(1'b0, 1'b1, cc);
            if (was_ready) accepted++;
            $display("sat %0d: code=%0d grant=%03b done=%0d count=%0d", i, cc, gnt[1], dn[1], cnt[1]);
        end
        chk("sat_accepted", 32'(accepted), 32'd300);
        chk("sat_count_h1", 32'(cnt[1]), 32'd255);
        chk("sat_count_h0", 32'(cnt[2]), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prio_grant_decoder.md
# prio_grant_decoder

Registered priority-code decoder: the receiving end of the three-line priority encoder's 2-bit output code. It accepts one code per valid/ready handshake and expands it back into a one-hot grant on lines a/b/c. It holds that grant for a fixed number of cycles, then pulses `done` and returns to accept the next code. It sits downstream of the priority encoder and drives the granted unit's enable.

## Interface
- `HOLD_CYCLES`, default 4: number of cycles each grant is held. Legal range 1..255; a value of 0 is treated as 1.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `code_in`  in  2  encoded request: bit1 = d (a|b), bit0 = e (a|~b&c).
- `code_valid`  in  1  `code_in` is valid this cycle.
- `code_ready`  out  1  block can accept a code this cycle.
- `grant`  out  3  one-hot grant: bit2 = a, bit1 = b, bit0 = c.
- `grant_valid`  out  1  high while `grant` is nonzero.
- `done`  out  1  one-cycle pulse on the last cycle of a grant.
- `grant_count`  out  8  number of grants issued; saturates at 255.

## Operation
- Code map: 11 → grant 100 (a), 10 → 010 (b), 01 → 001 (c), 00 → no request.
- Acceptance: a code is accepted at a rising edge where `code_valid` = 1, `code_ready` = 1 and `rst` = 0.
- Two states: IDLE and HOLD.
- IDLE: `code_ready` = 1, `grant` = 000.
  - Accepting a nonzero code latches the one-hot grant, loads the counter with HOLD_CYCLES−1, increments `grant_count` and moves to HOLD.
  - Accepting 00 completes the handshake and is discarded: state stays IDLE, no grant, no count.
- HOLD: `code_ready` = 0, `grant` is held constant, and `code_in`/`code_valid` are ignored.
  - The counter decrements once per cycle.
  - On the cycle the counter reads 0, `done` = 1. At the next edge the state returns to IDLE, `grant` clears and `code_ready` rises.
- No preemption: a higher-priority code arriving during HOLD waits until the block is back in IDLE.
- `grant_count` increments by 1 per accepted nonzero code and holds at 255 (no wrap).
- Counter width is 8 bits. `HOLD_CYCLES` = 1 gives a HOLD of one cycle, with `done` high in that same cycle.
- All outputs are registered; there is no combinational path from input to output.

## Timing
- Reset values: `code_ready` = 0, `grant` = 000, `grant_valid` = 0, `done` = 0, `grant_count` = 0, state = IDLE, counter = 0.
- `code_ready` goes to 1 at the first edge with `rst` = 0, so the first code can be accepted one cycle after reset is released.
- Nonzero code accepted at edge k:
  - `grant`/`grant_valid` are asserted from cycle k+1 through cycle k+HOLD_CYCLES.
  - `done` is high in cycle k+HOLD_CYCLES only.
  - `code_ready` = 1 again in cycle k+HOLD_CYCLES+1.
- `grant_count` shows its new value from cycle k+1.
- Back-to-back throughput: one grant per HOLD_CYCLES+1 cycles, because there is a mandatory IDLE cycle between grants.
- A code 00 accepted in IDLE leaves `code_ready` = 1 continuously; the block can accept a code every cycle.
- Reset mid-HOLD: at the next edge `grant` clears, no `done` pulse is produced, and `grant_count` clears.
- Simultaneous `rst` and `code_valid`: reset wins and the code is not accepted.

## Test plan
- Reset, then release: `code_ready` is 0 during reset and 1 one cycle after release; all other outputs are 0.
- HOLD_CYCLES = 4, code 11 accepted at edge k: `grant` = 100 for cycles k+1..k+4, `done` only at k+4, `code_ready` back at k+5, `grant_count` = 1.
- Codes 10 then 01 held valid back-to-back: grants 010 then 001, each lasting 4 cycles, with exactly one `code_ready` = 1 cycle between them. Code changes during HOLD have no effect.
- Code 00 with valid for 3 cycles: all three handshakes complete, `grant` stays 000, `grant_count` is unchanged.
- HOLD_CYCLES = 1, 300 consecutive nonzero codes: each grant lasts 1 cycle with `done` in the same cycle, and `grant_count` saturates at 255.
- Assert `rst` on the 2nd HOLD cycle of a grant: the next cycle shows `grant` = 000, `done` = 0, `grant_count` = 0; the block accepts a new code one cycle after `rst` falls.
